// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode encodings and a constant log2 helper shared by the FIFO files
package fifo_pkg;
  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: unreset register array with one clocked write port and one asynchronous read port
module sync_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int A_SIZE     = 3
) (
  input  logic                  i_clk,
  input  logic                  i_wen,
  input  logic [A_SIZE-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [A_SIZE-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  // store the write word; contents survive reset and flush
  always_ff @(posedge i_clk) begin
    if (i_wen) r_mem[i_waddr] <= i_wdata;
  end
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, any depth, registered or fall-through read, thresholds, sticky errors, flush
module sync_fifo
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  parameter  int FWFT       = FIFO_MODE_REG,
  parameter  int AF_LEVEL   = DEPTH - 2,
  parameter  int AE_LEVEL   = 1,
  localparam int A_SIZE     = clog2(DEPTH),
  localparam int L_SIZE     = clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_w_inc,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_r_inc,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [L_SIZE-1:0]     o_level,
  output logic                  o_overflow,
  output logic                  o_underflow
);
  if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1 ||
      (FWFT != FIFO_MODE_REG && FWFT != FIFO_MODE_FWFT)) begin : g_bad_param
    $error("sync_fifo: illegal DEPTH, FWFT or threshold parameter");
  end
  logic [A_SIZE-1:0]     r_wr_ptr, r_rd_ptr, w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [L_SIZE-1:0]     r_count;
  logic [DATA_WIDTH-1:0] r_rd_data, w_mem_rdata;
  logic                  r_overflow, r_underflow, w_wr_ok, w_rd_ok;
  // accepts are judged on the registered flags; flush blocks both sides
  assign w_wr_ok = i_w_inc & ~o_full & ~i_clr;
  assign w_rd_ok = i_r_inc & ~o_empty & ~i_clr;
  // pointers wrap by explicit compare so non-power-of-two depths work
  always_comb begin
    w_wr_ptr_nxt = (r_wr_ptr == A_SIZE'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    w_rd_ptr_nxt = (r_rd_ptr == A_SIZE'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
  end
  // pointers, occupancy count and sticky error flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_ok) r_rd_ptr <= w_rd_ptr_nxt;
      if (w_wr_ok && !w_rd_ok) r_count <= r_count + 1'b1;
      else if (w_rd_ok && !w_wr_ok) r_count <= r_count - 1'b1;
      if (i_w_inc && o_full) r_overflow <= 1'b1;
      if (i_r_inc && o_empty) r_underflow <= 1'b1;
    end
  end
  // registered-read output stage; flush leaves it untouched
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rd_data <= '0;
    else if (w_rd_ok) r_rd_data <= w_mem_rdata;
  end
  sync_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .A_SIZE    (A_SIZE)
  ) u_mem (
    .i_clk  (i_clk),
    .i_wen  (w_wr_ok),
    .i_waddr(r_wr_ptr),
    .i_wdata(i_wr_data),
    .i_raddr(r_rd_ptr),
    .o_rdata(w_mem_rdata)
  );
  assign o_rd_data      = (FWFT == FIFO_MODE_FWFT) ? w_mem_rdata : r_rd_data;
  assign o_level        = r_count;
  assign o_full         = r_count == L_SIZE'(DEPTH);
  assign o_empty        = r_count == '0;
  assign o_almost_full  = r_count >= L_SIZE'(AF_LEVEL);
  assign o_almost_empty = r_count <= L_SIZE'(AE_LEVEL);
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed checks of a DEPTH=6 FIFO in registered-read and fall-through modes
module tb_sync_fifo;
  import fifo_pkg::*;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       w_inc = 1'b0;
  logic       r_inc = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd0, rd1;
  logic [2:0] lvl0, lvl1;
  logic       full0, empty0, af0, ae0, ovf0, udf0;
  logic       full1, empty1, af1, ae1, ovf1, udf1;
  int         n_checks = 0;
  int         n_errors = 0;
  always #5 clk = ~clk;
  sync_fifo #(.DATA_WIDTH(8), .DEPTH(6), .FWFT(FIFO_MODE_REG), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut_reg (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_w_inc(w_inc), .i_wr_data(wr_data), .i_r_inc(r_inc),
    .o_rd_data(rd0), .o_full(full0), .o_empty(empty0), .o_almost_full(af0), .o_almost_empty(ae0),
    .o_level(lvl0), .o_overflow(ovf0), .o_underflow(udf0)
  );
  sync_fifo #(.DATA_WIDTH(8), .DEPTH(6), .FWFT(FIFO_MODE_FWFT), .AF_LEVEL(4), .AE_LEVEL(1)) u_dut_fwft (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr(clr), .i_w_inc(w_inc), .i_wr_data(wr_data), .i_r_inc(r_inc),
    .o_rd_data(rd1), .o_full(full1), .o_empty(empty1), .o_almost_full(af1), .o_almost_empty(ae1),
    .o_level(lvl1), .o_overflow(ovf1), .o_underflow(udf1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  // drive one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    w_inc = w;
    wr_data = d;
    r_inc = r;
    clr = c;
    @(posedge clk);
    #1;
    w_inc = 1'b0;
    r_inc = 1'b0;
    clr = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 32'(lvl0), 0);
    check("rst_empty", 32'(empty0), 1);
    check("rst_aempty", 32'(ae0), 1);
    check("rst_full", 32'(full0), 0);
    check("rst_afull", 32'(af0), 0);
    check("rst_ovf", 32'(ovf0), 0);
    check("rst_udf", 32'(udf0), 0);
    check("rst_rd_data", 32'(rd0), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      check("fill_level", 32'(lvl0), 32'(i + 1));
      check("fill_afull", 32'(af0), 32'(i >= 3));
      check("fill_full", 32'(full0), 32'(i == 5));
      check("fill_aempty", 32'(ae0), 32'(i == 0));
      check("fill_empty", 32'(empty0), 0);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain_data", 32'(rd0), 32'(8'h10 + i));
      check("drain_level", 32'(lvl0), 32'(5 - i));
    end
    check("drain_empty", 32'(empty0), 1);
    check("drain_full", 32'(full0), 0);
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_level", 32'(lvl0), 6);
    check("ovf_flag", 32'(ovf0), 1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("ovf_drain_data", 32'(rd0), 32'(8'h20 + i));
    end
    check("ovf_sticky", 32'(ovf0), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("udf_flag", 32'(udf0), 1);
    check("udf_level", 32'(lvl0), 0);
    check("udf_rd_hold", 32'(rd0), 32'h25);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", 32'(ovf0), 0);
    check("clr_udf", 32'(udf0), 0);
    check("clr_rd_hold", 32'(rd0), 32'h25);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(8'h43 + i), 1'b1, 1'b0);
      check("wrap_data", 32'(rd0), 32'(8'h40 + i));
      check("wrap_level", 32'(lvl0), 3);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check("wrap_tail", 32'(rd0), 32'(8'h54 + i));
    end
    check("wrap_empty", 32'(empty0), 1);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("both_empty_level", 32'(lvl0), 1);
    check("both_empty_udf", 32'(udf0), 1);
    check("both_empty_rd", 32'(rd0), 32'h56);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h78 + i), 1'b0, 1'b0);
    check("refill_full", 32'(full0), 1);
    step(1'b1, 8'h99, 1'b1, 1'b0);
    check("both_full_level", 32'(lvl0), 5);
    check("both_full_ovf", 32'(ovf0), 1);
    check("both_full_rd", 32'(rd0), 32'h77);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_level", 32'(lvl0), 0);
    check("fwft_clr_empty", 32'(empty1), 1);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    check("fwft_empty", 32'(empty1), 0);
    check("fwft_head", 32'(rd1), 32'h3C);
    step(1'b1, 8'h3D, 1'b0, 1'b0);
    check("fwft_head_hold", 32'(rd1), 32'h3C);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("fwft_pop_next", 32'(rd1), 32'h3D);
    check("fwft_pop_level", 32'(lvl1), 1);
    check("reg_pop_data", 32'(rd0), 32'h3C);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    check("pre_rst_level", 32'(lvl0), 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_level", 32'(lvl0), 0);
    check("arst_empty", 32'(empty0), 1);
    check("arst_rd_data", 32'(rd0), 0);
    check("arst_fwft_empty", 32'(empty1), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    check("pre_clr_level", 32'(lvl0), 4);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check("clrw_level", 32'(lvl0), 0);
    check("clrw_empty", 32'(empty0), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("clrw_dropped", 32'(lvl0), 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("clrw_read_udf", 32'(udf0), 1);
    check("clrw_rd_hold", 32'(rd0), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
